pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program counter for the 6502-derived core: single clock, generic width.
//  Redirect requests (absolute jump, relative branch, call, return) are carried through a configurable
//  resolution delay line, then applied to the PC. Includes a hardware return-address stack.
//  A redirect that matures while the PC is stalled is held until the next enabled update, not lost.
//  Feeds the instruction-memory address port; redirects come from the branch resolve stage.
// PARAMETERS
//  PC_WIDTH      8     PC / address width in bits
//  RESET_VECTOR  '1    PC value after reset; all-ones so the first increment fetches address 0
//  BRANCH_DELAY  4     cycles from redir_valid to request maturity; legal range 0..8
//  STACK_DEPTH   4     return-address stack entries; legal range 1..16
// PORTS
//  clka          in   1                     clock; all state updates on posedge
//  restart_n     in   1                     asynchronous active-low reset
//  pc_en         in   1                     PC update enable; low = stall, PC holds
//  flush         in   1                     discard all in-flight and pending redirects
//  redir_valid   in   1                     redirect request strobe, one request per cycle
//  redir_op      in   2                     00 JMP abs, 01 BR rel, 10 CALL abs, 11 RET
//  redir_addr    in   PC_WIDTH              absolute target (JMP/CALL); signed offset (BR); ignored (RET)
//  pc_out        out  PC_WIDTH              registered current PC
//  redir_pending out  1                     a matured redirect is waiting for pc_en
//  redir_lost    out  1                     one-cycle pulse: pending redirect overwritten by a newer one
//  stack_depth   out  $clog2(STACK_DEPTH+1) occupied stack entries
//  stack_err     out  1                     sticky flag: push on full or pop on empty
// BEHAVIOUR
//  Reset (async assert; deassert sampled on posedge):
//   - pc_out = RESET_VECTOR; delay line, pending slot and stack empty
//   - redir_pending, redir_lost, stack_err = 0; stack_depth = 0
//  Delay line: BRANCH_DELAY stages of {valid, op, addr}.
//   - Shifts every cycle, independent of pc_en.
//   - A request accepted at edge t matures at the output at edge t+BRANCH_DELAY.
//   - BRANCH_DELAY = 0: request is mature in its own cycle (combinational bypass).
//  Maturity:
//   - pc_en = 1 that cycle: applied at that edge.
//   - pc_en = 0: latched into the pending slot; redir_pending = 1.
//   - Pending slot already full: newer request overwrites it and redir_lost pulses one cycle.
//  Per-edge update priority:
//   - pc_en = 0: PC holds.
//   - Otherwise: apply the pending slot if full, else the matured request, else PC + 1.
//   - If the pending slot is applied and a request matures the same edge, the matured request
//     enters the pending slot.
//  Ops (all arithmetic modulo 2^PC_WIDTH; wrap silently, 0xFF+1 = 0x00 at width 8):
//   - JMP:  PC <= redir_addr
//   - BR:   PC <= PC + redir_addr, redir_addr as two's complement (0xFE = -2); PC is the value at apply
//   - CALL: push PC+1; PC <= redir_addr. Full stack: push dropped, stack_err set, jump still taken
//   - RET:  pop; PC <= popped value. Empty stack: PC <= PC+1, stack_err set
//  stack_err clears only on reset.
//  flush: clears the delay line and pending slot at the edge. redir_valid in the same cycle is still
//   accepted into stage 1. A request maturing in the flush cycle is discarded. PC takes its normal
//   pc_en update, as increment only.
//  Reset mid-operation: all in-flight requests and stack contents are discarded.
// STRUCTURE
//  pc_pkg:  redir_op_e enum (OP_JMP, OP_BR, OP_CALL, OP_RET); redir_req_t struct {valid, op, addr}.
//  Sub-module pc_return_stack: LIFO with push/pop/full/empty/depth and async active-low reset.
//   Push and pop in the same cycle is illegal by construction.
//  Top level: delay line (generate loop), pending slot, next-PC mux.
// TESTING
//  1. Reset, pc_en=1 for 3 cycles -> pc_out 0xFF, 0x00, 0x01, 0x02.
//  2. BRANCH_DELAY=4: JMP 0x40 at cycle 10 -> pc_out = 0x40 after edge 14, then 0x41.
//  3. BR offset 0xFE applied at PC=0x10 -> PC 0x0E. Offset 0x05 at PC=0xFD -> 0x02 (wrap).
//  4. Request matures with pc_en=0 for 3 cycles -> redir_pending=1, PC held; applied on the first
//     pc_en=1 edge. A second maturity while pending -> redir_lost pulse, newer target wins.
//  5. STACK_DEPTH=2: CALL 0x80 at PC 0x10, CALL 0x90, CALL 0xA0 -> third sets stack_err, depth 2.
//     RET, RET -> PC 0x81, then 0x11. Third RET -> PC+1, stack_err stays 1.
//  6. flush with two requests in flight plus redir_valid the same cycle -> only the new request
//     takes effect. Async reset mid-flight -> pc_out = 0xFF immediately, depth 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: redirect opcodes and the
// redirect request record carried through the resolution delay line.
package pc_pkg;

    typedef enum logic [1:0] {
        OP_JMP  = 2'b00,
        OP_BR   = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } redir_op_e;

    localparam int REQ_ADDR_W = 16;

    // Widest address supported; the top keeps its own PC_WIDTH-sized copy.
    typedef struct packed {
        logic                  valid;
        redir_op_e             op;
        logic [REQ_ADDR_W-1:0] addr;
    } redir_req_t;

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO. Push on full and pop on empty are ignored
// here; the caller reports them. Push and pop never occur together.
module pc_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    assign full     = (depth == DW'(DEPTH));
    assign empty    = (depth == '0);
    assign top_data = mem[AW'(depth - 1'b1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

    // Entries are only meaningful below depth, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(depth)] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with delayed redirects (JMP/BR/CALL/RET), a one-entry
// pending slot for redirects that mature during a stall, and a return stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1,
    parameter int                  BRANCH_DELAY = 4,
    parameter int                  STACK_DEPTH  = 4
) (
    input  logic                               clka,
    input  logic                               restart_n,
    input  logic                               pc_en,
    input  logic                               flush,
    input  logic                               redir_valid,
    input  logic [1:0]                         redir_op,
    input  logic [PC_WIDTH-1:0]                redir_addr,
    output logic [PC_WIDTH-1:0]                pc_out,
    output logic                               redir_pending,
    output logic                               redir_lost,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               stack_err
);

    logic                mat_vld;
    redir_op_e           mat_op;
    logic [PC_WIDTH-1:0] mat_addr;

    logic                pend_vld, pend_vld_next;
    redir_op_e           pend_op, pend_op_next;
    logic [PC_WIDTH-1:0] pend_addr, pend_addr_next;

    logic                app_vld;
    redir_op_e           app_op;
    logic [PC_WIDTH-1:0] app_addr;

    logic [PC_WIDTH-1:0] pc_inc, pc_next, stk_top;
    logic                lost_next, err_set, push, pop, stk_full, stk_empty;

    // Resolution delay line: stage 0 always loads, later stages are cleared by flush.
    if (BRANCH_DELAY == 0) begin : g_bypass
        assign mat_vld  = redir_valid;
        assign mat_op   = redir_op_e'(redir_op);
        assign mat_addr = redir_addr;
    end else begin : g_line
        for (genvar g = 0; g < BRANCH_DELAY; g++) begin : g_stage
            logic                vld_p;
            redir_op_e           op_p;
            logic [PC_WIDTH-1:0] addr_p;
            if (g == 0) begin : g_head
                always_ff @(posedge clka or negedge restart_n) begin
                    if (!restart_n) vld_p <= 1'b0;
                    else            vld_p <= redir_valid;
                end
                always_ff @(posedge clka) begin
                    op_p   <= redir_op_e'(redir_op);
                    addr_p <= redir_addr;
                end
            end else begin : g_tail
                always_ff @(posedge clka or negedge restart_n) begin
                    if (!restart_n) vld_p <= 1'b0;
                    else            vld_p <= g_stage[g-1].vld_p && !flush;
                end
                always_ff @(posedge clka) begin
                    op_p   <= g_stage[g-1].op_p;
                    addr_p <= g_stage[g-1].addr_p;
                end
            end
        end
        assign mat_vld  = g_stage[BRANCH_DELAY-1].vld_p;
        assign mat_op   = g_stage[BRANCH_DELAY-1].op_p;
        assign mat_addr = g_stage[BRANCH_DELAY-1].addr_p;
    end

    // Pending slot and redirect selection; a flushed maturity is simply dropped.
    always_comb begin
        pend_vld_next  = pend_vld;
        pend_op_next   = pend_op;
        pend_addr_next = pend_addr;
        lost_next      = 1'b0;
        app_vld        = 1'b0;
        app_op         = OP_JMP;
        app_addr       = '0;
        if (flush) begin
            pend_vld_next = 1'b0;
        end else if (pc_en) begin
            if (pend_vld) begin
                app_vld        = 1'b1;
                app_op         = pend_op;
                app_addr       = pend_addr;
                pend_vld_next  = mat_vld;
                pend_op_next   = mat_op;
                pend_addr_next = mat_addr;
            end else if (mat_vld) begin
                app_vld  = 1'b1;
                app_op   = mat_op;
                app_addr = mat_addr;
            end
        end else if (mat_vld) begin
            pend_vld_next  = 1'b1;
            pend_op_next   = mat_op;
            pend_addr_next = mat_addr;
            lost_next      = pend_vld;
        end
    end

    // Next-PC mux and stack control.
    assign pc_inc = pc_out + 1'b1;

    always_comb begin
        pc_next = pc_out;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (pc_en) begin
            pc_next = pc_inc;
            if (app_vld) begin
                case (app_op)
                    OP_JMP: pc_next = app_addr;
                    OP_BR:  pc_next = pc_out + app_addr;
                    OP_CALL: begin
                        push    = !stk_full;
                        err_set = stk_full;
                        pc_next = app_addr;
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_set = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            pc_next = stk_top;
                        end
                    end
                    default: pc_next = pc_inc;
                endcase
            end
        end
    end

    pc_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clka),
        .rst_n     (restart_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .depth     (stack_depth)
    );

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            pc_out     <= RESET_VECTOR;
            pend_vld   <= 1'b0;
            redir_lost <= 1'b0;
            stack_err  <= 1'b0;
        end else begin
            pc_out     <= pc_next;
            pend_vld   <= pend_vld_next;
            redir_lost <= lost_next;
            stack_err  <= stack_err | err_set;
        end
    end

    always_ff @(posedge clka) begin
        pend_op   <= pend_op_next;
        pend_addr <= pend_addr_next;
    end

    assign redir_pending = pend_vld;

endmodule
